leb128_reader: RTL and testbench

Byte-stream initiator on the ROM read interface: it fetches consecutive bytes from the ROM and decodes one unsigned or signed LEB128 integer, up to 32 bits. The result and the address following the last consumed byte are returned with a one-cycle `done` pulse. It sits between the wasm front-end (the requester) and the `rom` byte responder, and replaces open-coded byte fetch loops for section sizes, indices and `i32` immediates.

---
 rtl/leb128_reader.sv | 140 ++++++++++++++
 tb/tb_leb128_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_reader.sv
// Fetches ROM bytes and decodes one unsigned/signed LEB128 value (<=32 bits); n bytes take 3n cycles plus ROM waits.
// Stalls in REQ until rom_ready, aborting after TIMEOUT cycles; start is accepted only while idle.
module leb128_reader #(
    parameter int MAX_BYTES = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] start_addr_i,
    input  logic        signed_mode_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_read_en_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] value_o,
    output logic [31:0] next_addr_o,
    output logic [2:0]  byte_count_o
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    MAX_CNT  = 3'(MAX_BYTES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, GAP, FIN, ERR} state_t;

    state_t        state_q;
    logic [31:0]   acc_q, cur_addr_q, rom_addr_q, value_q, next_addr_q;
    logic [5:0]    shift_q;
    logic [2:0]    cnt_q, byte_count_q;
    logic [TW-1:0] tmo_q;
    logic          signed_q, rom_read_en_q, busy_q, done_q, error_q;

    logic [31:0]   acc_d, value_d, addr_d, sext;
    logic [5:0]    shift_d;
    logic [2:0]    cnt_d;

    // Payload bits shifted past bit 31 fall off; sign fill only when the value is narrower than 32 bits.
    always_comb begin
        acc_d   = acc_q | (32'(rom_data_i[6:0]) << shift_q);
        shift_d = shift_q + 6'd7;
        cnt_d   = cnt_q + 3'd1;
        addr_d  = cur_addr_q + 32'd1;
        sext    = '0;
        if (signed_q && rom_data_i[6] && (shift_d < 6'd32)) begin
            sext = ~((32'd1 << shift_d) - 32'd1);
        end
        value_d = acc_d | sext;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cur_addr_q    <= '0;
            rom_addr_q    <= '0;
            value_q       <= '0;
            next_addr_q   <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            byte_count_q  <= '0;
            tmo_q         <= '0;
            signed_q      <= 1'b0;
            rom_read_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cur_addr_q    <= start_addr_i;
                        rom_addr_q    <= start_addr_i;
                        signed_q      <= signed_mode_i;
                        acc_q         <= '0;
                        shift_q       <= '0;
                        cnt_q         <= '0;
                        tmo_q         <= '0;
                        rom_read_en_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (rom_ready_i) begin
                        acc_q         <= acc_d;
                        shift_q       <= shift_d;
                        cnt_q         <= cnt_d;
                        cur_addr_q    <= addr_d;
                        rom_read_en_q <= 1'b0;
                        if (!rom_data_i[7]) begin
                            value_q      <= value_d;
                            next_addr_q  <= addr_d;
                            byte_count_q <= cnt_d;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= FIN;
                        end else if (cnt_d == MAX_CNT) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ERR;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        rom_read_en_q <= 1'b0;
                        error_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                // The ROM only answers a fresh assertion, so each byte gets a dropped-then-raised request.
                GAP: begin
                    rom_addr_q    <= cur_addr_q;
                    rom_read_en_q <= 1'b1;
                    tmo_q         <= '0;
                    state_q       <= REQ;
                end
                FIN:     state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign rom_read_en_o = rom_read_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign value_o       = value_q;
    assign next_addr_o   = next_addr_q;
    assign byte_count_o  = byte_count_q;
endmodule

// File: tb/tb_leb128_reader.sv
// Bench for leb128_reader: registered ROM responder with per-byte waits, per-cycle compare against a decode/timeline model.
module tb_leb128_reader;
    localparam int TIMEOUT = 16;
    localparam int MAXB    = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, signed_mode, rom_read_en, rom_ready, busy, done, error;
    logic [31:0] start_addr, rom_addr, value, next_addr;
    logic [7:0]  rom_data;
    logic [2:0]  byte_count;

    always #5 clk = ~clk;

    leb128_reader #(.MAX_BYTES(MAXB), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
        .signed_mode_i(signed_mode), .rom_addr_o(rom_addr), .rom_read_en_o(rom_read_en),
        .rom_data_i(rom_data), .rom_ready_i(rom_ready), .busy_o(busy), .done_o(done),
        .error_o(error), .value_o(value), .next_addr_o(next_addr), .byte_count_o(byte_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // ROM responder: answers each new request one cycle (+wait) later; a wait of -1 never answers.
    logic [7:0]  mem [1024];
    int          wait_q[$];
    int          rsp_cnt = 0;
    int          rsp_w;
    bit          rsp_seen = 0;
    bit          force_rdy = 0;
    logic [31:0] rsp_addr = '0;

    initial begin
        rom_ready = 1'b0;
        rom_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rom_ready = 1'b0;
            rom_data  = 8'($urandom);
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rom_ready = 1'b1;
                    rom_data  = mem[rsp_addr[9:0]];
                end
            end else if (rom_read_en && !rsp_seen) begin
                rsp_seen = 1;
                rsp_addr = rom_addr;
                rsp_w    = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                rsp_cnt  = (rsp_w < 0) ? 0 : 1 + rsp_w;
            end
            if (!rom_read_en) begin
                rsp_seen = 0;
                rsp_cnt  = 0;
            end
            if (force_rdy) rom_ready = 1'b1;
        end
    end

    // Expected timeline for the current operation, indexed by cycles since start was raised.
    bit          op_active = 0;
    int          base = 0;
    int          end_rel = 0;
    int          rel;
    bit          exp_err = 0;
    bit          exp_ren [64];
    logic [31:0] exp_addr [64];
    logic [31:0] old_val = 0, old_next = 0, new_val = 0, new_next = 0;
    logic [2:0]  old_bc = 0, new_bc = 0;
    logic [31:0] mdl_val = 0, mdl_next = 0;
    logic [2:0]  mdl_bc = 0;
    logic [31:0] last_val = 0, last_next = 0;
    logic [2:0]  last_bc = 0;
    bit          post;

    always @(negedge clk) begin
        if (op_active) begin
            rel = cyc - base;
            if (rel >= 0 && rel < 64) begin
                post = (rel >= end_rel) && !exp_err;
                chk1("done", done, (rel == end_rel) && !exp_err);
                chk1("error", error, (rel == end_rel) && exp_err);
                chk1("rom_read_en", rom_read_en, exp_ren[rel]);
                if (exp_ren[rel]) chk32("rom_addr", rom_addr, exp_addr[rel]);
                if (rel >= 1 && rel < end_rel) chk1("busy", busy, 1'b1);
                else if (rel != end_rel) chk1("busy", busy, 1'b0);
                chk32("value", value, post ? new_val : old_val);
                chk32("next_addr", next_addr, post ? new_next : old_next);
                chk32("byte_count", 32'(byte_count), 32'(post ? new_bc : old_bc));
            end
        end
        if (done) begin
            last_val  = value;
            last_next = next_addr;
            last_bc   = byte_count;
        end
    end

    logic [7:0]  op_b [MAXB];
    int          op_w [MAXB];
    bit          op_never = 0;
    logic [31:0] chain_addr = 0;
    bit          chain_sgn = 0;

    task automatic set_op(input logic [7:0] b0, b1, b2, b3, b4);
        op_b[0] = b0; op_b[1] = b1; op_b[2] = b2; op_b[3] = b3; op_b[4] = b4;
        for (int i = 0; i < MAXB; i++) op_w[i] = 0;
        op_never = 0;
    endtask

    task automatic run_op(input logic [31:0] addr, input bit sgn, input bit chain, input bit poke);
        logic [63:0] acc;
        logic [31:0] a;
        int n, t;
        bit err;
        acc = '0; n = 0; t = 1; err = 0;
        for (int r = 0; r < 64; r++) begin
            exp_ren[r]  = 0;
            exp_addr[r] = '0;
        end
        wait_q.delete();
        if (op_never) begin
            for (int r = 1; r <= TIMEOUT; r++) begin
                exp_ren[r]  = 1;
                exp_addr[r] = addr;
            end
            end_rel = TIMEOUT + 1;
            err = 1;
            wait_q.push_back(-1);
        end else begin
            for (int i = 0; i < MAXB; i++) begin
                a = addr + 32'(i);
                mem[a[9:0]] = op_b[i];
                wait_q.push_back(op_w[i]);
                for (int r = t; r <= t + 1 + op_w[i]; r++) begin
                    exp_ren[r]  = 1;
                    exp_addr[r] = a;
                end
                acc = acc | (64'(op_b[i][6:0]) << (7 * i));
                n = i + 1;
                if (!op_b[i][7]) begin
                    end_rel = t + 2 + op_w[i];
                    break;
                end
                if (i == MAXB - 1) begin
                    err = 1;
                    end_rel = t + 2 + op_w[i];
                    break;
                end
                t += 3 + op_w[i];
            end
        end
        old_val = mdl_val; old_next = mdl_next; old_bc = mdl_bc;
        exp_err = err;
        if (!err) begin
            if (sgn && op_b[n-1][6] && (7 * n < 32)) acc = acc | ~((64'd1 << (7 * n)) - 64'd1);
            mdl_val  = acc[31:0];
            mdl_next = addr + 32'(n);
            mdl_bc   = 3'(n);
        end
        new_val = mdl_val; new_next = mdl_next; new_bc = mdl_bc;
        start = 1'b1; start_addr = addr; signed_mode = sgn;
        base = cyc; op_active = 1;
        @(posedge clk); #1;
        start = 1'b0; start_addr = $urandom; signed_mode = 1'($urandom);
        while (cyc - base < end_rel) begin
            @(posedge clk); #1;
            if (poke) begin
                start      = (cyc - base == 2);
                start_addr = $urandom;
            end
        end
        if (chain) begin
            start = 1'b1; start_addr = chain_addr; signed_mode = chain_sgn;
            @(posedge clk); #1;
        end else begin
            start = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            op_active = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ov;
        rst_n = 1'b1; start = 1'b0; start_addr = '0; signed_mode = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        chk1("reset rom_read_en", rom_read_en, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset error", error, 1'b0);
        chk32("reset rom_addr", rom_addr, 32'h0);
        chk32("reset value", value, 32'h0);
        chk32("reset next_addr", next_addr, 32'h0);
        chk32("reset byte_count", 32'(byte_count), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        set_op(8'h08, 0, 0, 0, 0); run_op(32'h10, 0, 0, 0);
        chk32("pin 08 value", last_val, 32'h8);
        chk32("pin 08 next_addr", last_next, 32'h11);
        chk32("pin 08 byte_count", 32'(last_bc), 32'h1);

        set_op(8'hE5, 8'h8E, 8'h26, 0, 0); run_op(32'h20, 0, 0, 0);
        chk32("pin E58E26 value", last_val, 32'h00098765);
        chk32("pin E58E26 next_addr", last_next, 32'h23);
        chk32("pin E58E26 byte_count", 32'(last_bc), 32'h3);

        set_op(8'h7F, 0, 0, 0, 0); run_op(32'h30, 1, 0, 0);
        chk32("pin s7F", last_val, 32'hFFFFFFFF);
        set_op(8'hC0, 8'hBB, 8'h78, 0, 0); run_op(32'h40, 1, 0, 0);
        chk32("pin sC0BB78", last_val, 32'hFFFE1DC0);
        set_op(8'h3F, 0, 0, 0, 0); run_op(32'h48, 1, 0, 0);
        chk32("pin s3F", last_val, 32'h0000003F);
        set_op(8'h7F, 0, 0, 0, 0); run_op(32'h4C, 0, 0, 0);
        chk32("pin u7F", last_val, 32'h0000007F);

        set_op(8'h80, 8'h80, 8'h80, 8'h80, 8'h80); run_op(32'h50, 0, 0, 0);
        chk32("overlong value held", value, 32'h0000007F);
        set_op(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F); run_op(32'h58, 0, 0, 0);
        chk32("pin 5-byte value", last_val, 32'hFFFFFFFF);
        chk32("pin 5-byte count", 32'(last_bc), 32'h5);

        set_op(8'h01, 0, 0, 0, 0); op_never = 1; run_op(32'h60, 0, 0, 0);
        chk1("timeout busy low", busy, 1'b0);
        chk1("timeout read_en low", rom_read_en, 1'b0);
        op_never = 0;

        set_op(8'hE5, 8'h8E, 8'h26, 0, 0);
        op_w[0] = 2; op_w[1] = 0; op_w[2] = 3;
        run_op(32'h70, 0, 0, 0);
        set_op(8'hC0, 8'hBB, 8'h78, 0, 0); run_op(32'h80, 1, 0, 1);
        set_op(8'h80, 8'h01, 0, 0, 0); run_op(32'hFFFFFFFF, 0, 0, 0);
        chk32("pin wrap value", last_val, 32'h80);
        chk32("pin wrap next_addr", last_next, 32'h1);

        chain_addr = 32'h90; chain_sgn = 1;
        set_op(8'h08, 0, 0, 0, 0); run_op(32'h88, 0, 1, 0);
        set_op(8'h7F, 0, 0, 0, 0); run_op(32'h90, 1, 0, 0);
        chk32("pin b2b value", last_val, 32'hFFFFFFFF);

        // Reset while the second byte is being requested.
        mem[10'h20] = 8'hE5; mem[10'h21] = 8'h8E; mem[10'h22] = 8'h26;
        wait_q.delete(); wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(0);
        start = 1'b1; start_addr = 32'h20; signed_mode = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk1("mid read_en before reset", rom_read_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("midrst rom_read_en", rom_read_en, 1'b0);
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk1("midrst error", error, 1'b0);
        chk32("midrst rom_addr", rom_addr, 32'h0);
        chk32("midrst value", value, 32'h0);
        chk32("midrst next_addr", next_addr, 32'h0);
        chk32("midrst byte_count", 32'(byte_count), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        wait_q.delete();
        mdl_val = 0; mdl_next = 0; mdl_bc = 0;
        repeat (3) begin @(posedge clk); #1; end
        force_rdy = 1;
        @(posedge clk); #1; force_rdy = 0;
        @(posedge clk); #1;
        chk1("stray ready busy", busy, 1'b0);
        chk1("stray ready done", done, 1'b0);
        chk32("stray ready value", value, 32'h0);
        set_op(8'hE5, 8'h8E, 8'h26, 0, 0); run_op(32'h20, 0, 0, 0);
        chk32("pin after reset", last_val, 32'h00098765);

        repeat (60) begin
            n  = $urandom_range(1, MAXB);
            ov = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < MAXB; i++) begin
                op_b[i]    = 8'($urandom);
                op_b[i][7] = ov || (i < n - 1);
                op_w[i]    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            end
            op_never = 0;
            run_op($urandom, 1'($urandom), 0, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
